gerar_sequencia: RTL

Sequence generator for the memory game: on request it draws two pseudo-random 4-bit sequences from a free-running LFSR. It plays them back to the player one bit position at a time on two LEDs, then holds them stable with `pronto` asserted. It is the producing end of the sequence path: its `sequencia_0`/`sequencia_1` outputs drive the checker's expected-sequence inputs, which compare them against the player's entries.

---
 rtl/gerar_sequencia.sv | 107 ++++++++++
 1 files changed

// File: rtl/gerar_sequencia.sv
// Memory-game sequence generator: draws two 4-bit sequences from a free-running
// LFSR, plays them back bit by bit on two LEDs, then holds them with pronto high.
//
// state  | meaning
// -------+-----------------------------------------------------------
// OCIOSO | idle, waiting for iniciar; last sequences held
// EXIBIR | playback, one bit position per TEMPO_BIT cycles, LSB first
// PRONTO | playback done, sequences valid; limpar or iniciar leaves
module gerar_sequencia #(
  parameter int          TEMPO_BIT = 4,
  parameter logic [7:0]  SEMENTE   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic       limpar,
  output logic [3:0] sequencia_0,
  output logic [3:0] sequencia_1,
  output logic [1:0] led,
  output logic [1:0] indice,
  output logic       exibindo,
  output logic       pronto
);

  // An all-zero LFSR would lock up, so a zero seed is forced to 1.
  localparam logic [7:0]  SEED  = (SEMENTE == 8'h00) ? 8'h01 : SEMENTE;
  localparam logic [15:0] CARGA = 16'(TEMPO_BIT - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EXIBIR = 2'd1,
    PRONTO = 2'd2
  } estado_t;

  estado_t     estado, prox;
  logic [7:0]  q;
  logic [15:0] cont;
  logic [1:0]  idx;
  logic        captura;
  logic        fim_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

  // Down-counter per bit position; terminal count marks the last cycle.
  assign fim_bit = (cont == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= prox;
  end

  always_comb begin
    prox    = estado;
    captura = 1'b0;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          captura = 1'b1;
          prox    = EXIBIR;
        end
      end
      EXIBIR: begin
        if (fim_bit && idx == 2'd3) prox = PRONTO;
      end
      PRONTO: begin
        if (limpar) begin
          prox = OCIOSO;
        end else if (iniciar) begin
          captura = 1'b1;
          prox    = EXIBIR;
        end
      end
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sequencia_0 <= 4'd0;
      sequencia_1 <= 4'd0;
      idx         <= 2'd0;
      cont        <= 16'd0;
    end else if (captura) begin
      sequencia_0 <= q[3:0];
      sequencia_1 <= q[7:4];
      idx         <= 2'd0;
      cont        <= CARGA;
    end else if (estado == EXIBIR) begin
      if (fim_bit) begin
        cont <= CARGA;
        // Wraps 3 -> 0 exactly on the move to PRONTO.
        idx  <= idx + 2'd1;
      end else begin
        cont <= cont - 16'd1;
      end
    end
  end

  assign exibindo = (estado == EXIBIR);
  assign pronto   = (estado == PRONTO);
  assign indice   = idx;
  assign led      = exibindo ? {sequencia_1[idx], sequencia_0[idx]} : 2'b00;

endmodule
